// File: rtl/mtime_counter.sv
// mtime_counter: free-running 64-bit machine timer for the CLINT.
// A prescaler divides the core clock down to a 1 MHz mtime increment, and
// mtip reports (mtime >= mtimecmp) one cycle after the registered mtime.
// Optional feature macro: MTIME_WRITE_EN adds a software write port that
// can load either 32-bit half of mtime independently.
module mtime_counter #(
    parameter int FMAX_MHz = 27
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] mtimecmp,
`ifdef MTIME_WRITE_EN
    input  logic        wr_valid,
    input  logic [1:0]  wr_mask,
    input  logic [63:0] wr_data,
`endif
    output logic [63:0] mtime,
    output logic        mtip,
    output logic        tick
);

    // A divide-by-one prescaler still needs one bit of storage.
    localparam int PW = (FMAX_MHz > 1) ? $clog2(FMAX_MHz) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(FMAX_MHz - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [63:0]   mtime_q, mtime_d;
    logic          mtip_q, mtip_d;
    logic          tick_q, tick_d;
    logic          presc_wrap;

    // Next-state: prescaler count, mtime increment/write and compare.
    always_comb begin
        presc_wrap = (presc_q == PRESC_MAX);
        presc_d    = presc_wrap ? '0 : presc_q + PW'(1);
        mtime_d    = presc_wrap ? mtime_q + 64'd1 : mtime_q;
        tick_d     = presc_wrap;
        // Compare uses the registered mtime, so mtip lags mtime by a cycle.
        mtip_d     = (mtime_q >= mtimecmp);
`ifdef MTIME_WRITE_EN
        // A write replaces only the selected halves; the unselected half
        // keeps its value with no carry, and any coincident increment is lost.
        if (wr_valid && (wr_mask != 2'b00)) begin
            mtime_d[31:0]  = wr_mask[0] ? wr_data[31:0]  : mtime_q[31:0];
            mtime_d[63:32] = wr_mask[1] ? wr_data[63:32] : mtime_q[63:32];
            presc_d        = '0;
            tick_d         = 1'b0;
        end
`endif
    end

    // State registers; reset wins over everything, including a write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q <= '0;
            mtime_q <= '0;
            mtip_q  <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            mtime_q <= mtime_d;
            mtip_q  <= mtip_d;
            tick_q  <= tick_d;
        end
    end

    assign mtime = mtime_q;
    assign mtip  = mtip_q;
    assign tick  = tick_q;

endmodule
